perm_ctl: RTL and testbench
===========================

PERM_CTL -- requirements
Module: perm_ctl

Interface
REQ-001 SHALL have parameter NROUNDS, default 24, number of permutation rounds per block.
REQ-002 SHALL have parameter LAT, default 1, bank read-to-data latency in cycles (1..3).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pushin  input  1  input lane word valid.
REQ-006 SHALL have port firstin  input  1  marks lane (0,0) of a 25-lane block.
REQ-007 SHALL have port stopin  output  1  backpressure to the upstream source.
REQ-008 SHALL have port pushout  output  1  output lane word valid.
REQ-009 SHALL have port firstout  output  1  marks output lane (0,0).
REQ-010 SHALL have port stopout  input  1  downstream backpressure.
REQ-011 SHALL have ports rax, ray  output  3 each  bank read lane x,y.
REQ-012 SHALL have port rsel  output  1  bank being read (0/1).
REQ-013 SHALL have ports wax, way  output  3 each  bank write lane x,y.
REQ-014 SHALL have port wr  output  1  write strobe; port wsel  output  1  bank being written.
REQ-015 SHALL have port rnd  output  5  current round index; port phase  output  2  state code.
REQ-016 SHALL have port err  output  1  one-cycle protocol-error pulse.

Function
REQ-017 Lane index i=0..24 SHALL map to x=i mod 5, y=i div 5 (x fastest) for all address outputs.
REQ-018 States SHALL be IDLE(phase 0), LOAD(1), ROUND(2), UNLOAD(3).
REQ-019 stopin SHALL be 0 in IDLE and LOAD, 1 in ROUND and UNLOAD.
REQ-020 IDLE: pushin&firstin SHALL assert wr, wsel=0, wax=way=0 that cycle, set lane count 1, go LOAD.
REQ-021 IDLE: pushin without firstin SHALL be dropped and pulse err next cycle.
REQ-022 LOAD: each pushin without firstin SHALL write lane count to bank 0 that cycle and increment count.
REQ-023 LOAD: pushin&firstin SHALL pulse err, write that word as lane 0 and set count to 1 (resync).
REQ-024 After the 25th lane write, SHALL enter ROUND next cycle with rnd=0, source bank 0.
REQ-025 ROUND: SHALL issue reads lanes 0..24 on 25 consecutive cycles, rsel=source.
REQ-026 ROUND: wr SHALL assert exactly LAT cycles after each read, wax/way equal to that read's address, wsel=~source.
REQ-027 Each round SHALL last 25+LAT cycles; then source toggles and rnd increments the next cycle.
REQ-028 After round NROUNDS-1 completes, SHALL enter UNLOAD with source = NROUNDS mod 2; rnd SHALL be 0 outside ROUND.
REQ-029 UNLOAD: SHALL issue a read of the next lane on each cycle stopout=0; no read while stopout=1.
REQ-030 UNLOAD: pushout SHALL assert LAT cycles after each issued read; firstout with lane 0's pushout only.
REQ-031 Reads in flight when stopout rises SHALL still push out (downstream absorbs up to LAT words).
REQ-032 After the 25th pushout SHALL return to IDLE next cycle.
REQ-033 pushin while stopin=1 SHALL be ignored with no err.
REQ-034 wr SHALL never assert outside LOAD and ROUND; no two writes to same lane within one round.

Reset
REQ-035 reset low SHALL immediately force IDLE, lane/round counters 0, all outputs 0, regardless of state.
REQ-036 Release of reset SHALL take effect on the next rising clk; no words are retained across reset.

Verification
REQ-037 25 pushin (first with firstin), NROUNDS=24, LAT=1, stopout=0 -> stopin rises 1 cycle after 25th write, ROUND lasts 624 cycles, rnd 0..23, 25 pushout, firstout on first, then IDLE.
REQ-038 Check ROUND addressing -> for every read (x,y,rsel) a write (x,y,~rsel) exactly 1 cycle later; rsel sequence 0,1,0,... ending UNLOAD rsel=0.
REQ-039 stopout high for 10 cycles after 3rd UNLOAD read -> exactly 1 further pushout, then none until release; total still 25 pushout, lanes in order.
REQ-040 pushin without firstin in IDLE -> err one cycle, no wr; firstin at LOAD lane 7 -> err, next writes restart at lane 0.
REQ-041 reset low during ROUND rnd=5 -> all outputs 0, phase 0 same cycle; new block loads normally.
REQ-042 NROUNDS=3, LAT=2 -> rounds of 27 cycles, UNLOAD rsel=1, pushout 2 cycles after each read.

Source files
------------

// File: rtl/perm_ctl.sv
// Sequencing controller for a 25-lane, two-bank iterated permutation:
// loads a block into bank 0, ping-pongs NROUNDS rounds between the banks, then streams the result out.
module perm_ctl #(
  parameter int NROUNDS = 24,
  parameter int LAT     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pushin,
  input  logic       firstin,
  output logic       stopin,
  output logic       pushout,
  output logic       firstout,
  input  logic       stopout,
  output logic [2:0] rax,
  output logic [2:0] ray,
  output logic       rsel,
  output logic [2:0] wax,
  output logic [2:0] way,
  output logic       wr,
  output logic       wsel,
  output logic [4:0] rnd,
  output logic [1:0] phase,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROUND  = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  localparam logic [4:0] LAT5    = 5'(LAT);
  localparam logic [4:0] RLAST   = 5'(24 + LAT);
  localparam logic [4:0] NRLAST  = 5'(NROUNDS - 1);
  localparam logic [4:0] LASTIDX = 5'd24;

  state_t         state, state_nx;
  logic [4:0]     lane, lane_nx;
  logic [4:0]     cyc, cyc_nx;
  logic [4:0]     rnd_q, rnd_nx;
  logic [4:0]     outcnt, outcnt_nx;
  logic           src, src_nx;
  logic           err_q, err_nx;
  logic           issue;
  logic [LAT-1:0] pv, pf;

  function automatic logic [5:0] lane_xy(input logic [4:0] i);
    return {3'(i / 5'd5), 3'(i % 5'd5)};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      lane   <= '0;
      cyc    <= '0;
      rnd_q  <= '0;
      outcnt <= '0;
      src    <= 1'b0;
      err_q  <= 1'b0;
      pv     <= '0;
      pf     <= '0;
    end else begin
      state  <= state_nx;
      lane   <= lane_nx;
      cyc    <= cyc_nx;
      rnd_q  <= rnd_nx;
      outcnt <= outcnt_nx;
      src    <= src_nx;
      err_q  <= err_nx;
      pv[0]  <= issue;
      pf[0]  <= issue && (lane == 5'd0);
      for (int k = 1; k < LAT; k++) begin
        pv[k] <= pv[k-1];
        pf[k] <= pf[k-1];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    lane_nx   = lane;
    cyc_nx    = cyc;
    rnd_nx    = rnd_q;
    outcnt_nx = outcnt;
    src_nx    = src;
    err_nx    = 1'b0;
    issue     = 1'b0;
    stopin    = 1'b0;
    rax       = '0;
    ray       = '0;
    rsel      = 1'b0;
    wax       = '0;
    way       = '0;
    wr        = 1'b0;
    wsel      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pushin) begin
          if (firstin) begin
            wr       = 1'b1;
            lane_nx  = 5'd1;
            state_nx = LOAD;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pushin) begin
          wr = 1'b1;
          // A stray first marker restarts the block at lane 0
          if (firstin) begin
            err_nx  = 1'b1;
            lane_nx = 5'd1;
          end else begin
            {way, wax} = lane_xy(lane);
            if (lane == LASTIDX) begin
              state_nx = ROUND;
              lane_nx  = '0;
              cyc_nx   = '0;
              rnd_nx   = '0;
              src_nx   = 1'b0;
            end else begin
              lane_nx = lane + 5'd1;
            end
          end
        end
      end
      ROUND: begin
        stopin = 1'b1;
        rsel   = src;
        wsel   = ~src;
        if (cyc < 5'd25) {ray, rax} = lane_xy(cyc);
        if (cyc >= LAT5) begin
          wr         = 1'b1;
          {way, wax} = lane_xy(cyc - LAT5);
        end
        if (cyc == RLAST) begin
          cyc_nx = '0;
          src_nx = ~src;
          if (rnd_q == NRLAST) begin
            state_nx  = UNLOAD;
            rnd_nx    = '0;
            lane_nx   = '0;
            outcnt_nx = '0;
          end else begin
            rnd_nx = rnd_q + 5'd1;
          end
        end else begin
          cyc_nx = cyc + 5'd1;
        end
      end
      UNLOAD: begin
        stopin = 1'b1;
        rsel   = src;
        if (!stopout && lane < 5'd25) begin
          issue      = 1'b1;
          {ray, rax} = lane_xy(lane);
          lane_nx    = lane + 5'd1;
        end
        // Reads already in flight keep draining regardless of stopout
        if (pv[LAT-1]) begin
          if (outcnt == LASTIDX) begin
            state_nx  = IDLE;
            lane_nx   = '0;
            outcnt_nx = '0;
            src_nx    = 1'b0;
          end else begin
            outcnt_nx = outcnt + 5'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!reset) wr = 1'b0;
  end

  assign pushout  = pv[LAT-1];
  assign firstout = pv[LAT-1] & pf[LAT-1];
  assign rnd      = rnd_q;
  assign phase    = state;
  assign err      = err_q;

endmodule

// File: tb/tb_perm_ctl.sv
// Self-checking bench for perm_ctl: two instances (24 rounds/LAT 1 and 3 rounds/LAT 2)
// checked cycle by cycle against an arithmetic timeline model.
module tb_perm_ctl;

  logic clk = 1'b0;
  logic reset;
  logic       pushin_v [2];
  logic       firstin_v [2];
  logic       stopout_v [2];
  logic       stopin_o [2];
  logic       pushout_o [2];
  logic       firstout_o [2];
  logic       rsel_o [2];
  logic       wr_o [2];
  logic       wsel_o [2];
  logic       err_o [2];
  logic [2:0] rax_o [2];
  logic [2:0] ray_o [2];
  logic [2:0] wax_o [2];
  logic [2:0] way_o [2];
  logic [4:0] rnd_o [2];
  logic [1:0] phase_o [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perm_ctl #(.NROUNDS(24), .LAT(1)) dut0 (
    .clk(clk), .reset(reset), .pushin(pushin_v[0]), .firstin(firstin_v[0]),
    .stopin(stopin_o[0]), .pushout(pushout_o[0]), .firstout(firstout_o[0]),
    .stopout(stopout_v[0]), .rax(rax_o[0]), .ray(ray_o[0]), .rsel(rsel_o[0]),
    .wax(wax_o[0]), .way(way_o[0]), .wr(wr_o[0]), .wsel(wsel_o[0]),
    .rnd(rnd_o[0]), .phase(phase_o[0]), .err(err_o[0])
  );

  perm_ctl #(.NROUNDS(3), .LAT(2)) dut1 (
    .clk(clk), .reset(reset), .pushin(pushin_v[1]), .firstin(firstin_v[1]),
    .stopin(stopin_o[1]), .pushout(pushout_o[1]), .firstout(firstout_o[1]),
    .stopout(stopout_v[1]), .rax(rax_o[1]), .ray(ray_o[1]), .rsel(rsel_o[1]),
    .wax(wax_o[1]), .way(way_o[1]), .wr(wr_o[1]), .wsel(wsel_o[1]),
    .rnd(rnd_o[1]), .phase(phase_o[1]), .err(err_o[1])
  );

  function automatic int nr_of(input int d);
    return (d == 0) ? 24 : 3;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input int d);
    check_output("rst_stopin",   32'(stopin_o[d]),   0);
    check_output("rst_pushout",  32'(pushout_o[d]),  0);
    check_output("rst_firstout", 32'(firstout_o[d]), 0);
    check_output("rst_rax",      32'(rax_o[d]),      0);
    check_output("rst_ray",      32'(ray_o[d]),      0);
    check_output("rst_rsel",     32'(rsel_o[d]),     0);
    check_output("rst_wax",      32'(wax_o[d]),      0);
    check_output("rst_way",      32'(way_o[d]),      0);
    check_output("rst_wr",       32'(wr_o[d]),       0);
    check_output("rst_wsel",     32'(wsel_o[d]),     0);
    check_output("rst_rnd",      32'(rnd_o[d]),      0);
    check_output("rst_phase",    32'(phase_o[d]),    0);
    check_output("rst_err",      32'(err_o[d]),      0);
  endtask

  // Push 25 lanes, optionally with random idle gaps and one mid-block first marker
  task automatic load_block(input int d, input int resync_at, input bit gaps);
    int lane_e = 0;
    int pushes = 0;
    bit err_next = 1'b0;
    bit f;
    while (lane_e < 25) begin
      @(posedge clk); #1;
      stopout_v[d] = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        pushin_v[d]  = 1'b0;
        firstin_v[d] = 1'b0;
        @(negedge clk);
        check_output("gap_wr",     32'(wr_o[d]),     0);
        check_output("gap_err",    32'(err_o[d]),    32'(err_next));
        check_output("gap_stopin", 32'(stopin_o[d]), 0);
        check_output("gap_phase",  32'(phase_o[d]),  (pushes == 0) ? 0 : 1);
        err_next = 1'b0;
      end else begin
        f = (pushes == 0) || (pushes == resync_at);
        if (f) lane_e = 0;
        pushin_v[d]  = 1'b1;
        firstin_v[d] = f;
        @(negedge clk);
        check_output("ld_wr",     32'(wr_o[d]),     1);
        check_output("ld_wsel",   32'(wsel_o[d]),   0);
        check_output("ld_wax",    32'(wax_o[d]),    lane_e % 5);
        check_output("ld_way",    32'(way_o[d]),    lane_e / 5);
        check_output("ld_stopin", 32'(stopin_o[d]), 0);
        check_output("ld_err",    32'(err_o[d]),    32'(err_next));
        check_output("ld_phase",  32'(phase_o[d]),  (pushes == 0) ? 0 : 1);
        err_next = f && (pushes != 0);
        lane_e++;
        pushes++;
      end
    end
  endtask

  // Round k of the timeline: read lane pos, write lane pos-LAT into the other bank
  task automatic run_rounds(input int d, input int abort_rnd);
    int n = nr_of(d);
    int l = lat_of(d);
    int len = 25 + l;
    int r;
    int pos;
    for (int k = 0; k < n * len; k++) begin
      r = k / len;
      pos = k % len;
      @(posedge clk); #1;
      pushin_v[d]  = 1'($urandom_range(0, 1));
      firstin_v[d] = 1'($urandom_range(0, 1));
      if (r == abort_rnd && pos == 3) begin
        reset = 1'b0;
        pushin_v[d]  = 1'b1;
        firstin_v[d] = 1'b1;
        #1;
        check_zero(d);
        repeat (2) begin
          @(negedge clk);
          check_zero(d);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        pushin_v[d]  = 1'b0;
        firstin_v[d] = 1'b0;
        return;
      end
      @(negedge clk);
      check_output("rd_phase",  32'(phase_o[d]),  2);
      check_output("rd_stopin", 32'(stopin_o[d]), 1);
      check_output("rd_rnd",    32'(rnd_o[d]),    r);
      check_output("rd_rsel",   32'(rsel_o[d]),   r % 2);
      check_output("rd_err",    32'(err_o[d]),    0);
      check_output("rd_push",   32'(pushout_o[d]), 0);
      if (pos < 25) begin
        check_output("rd_rax", 32'(rax_o[d]), pos % 5);
        check_output("rd_ray", 32'(ray_o[d]), pos / 5);
      end
      check_output("rd_wr", 32'(wr_o[d]), 32'(pos >= l));
      if (pos >= l) begin
        check_output("rd_wax",  32'(wax_o[d]),  (pos - l) % 5);
        check_output("rd_way",  32'(way_o[d]),  (pos - l) / 5);
        check_output("rd_wsel", 32'(wsel_o[d]), 1 - (r % 2));
      end
    end
  endtask

  // Pushout follows each issued read by LAT cycles; reads issue only while stopout is low
  task automatic run_unload(input int d, input bit stall);
    int n = nr_of(d);
    int l = lat_of(d);
    int iss = 0;
    int pout = 0;
    int j = 0;
    int stall_left = 0;
    bit stall_done = 1'b0;
    bit so;
    bit exp_issue;
    bit exp_push;
    bit exp_first;
    bit hist[$];
    int hl[$];
    while (pout < 25 && j < 300) begin
      @(posedge clk); #1;
      if (stall && iss == 3 && !stall_done) begin
        stall_left = 10;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        so = 1'b1;
        stall_left--;
      end else begin
        so = stall ? 1'b0 : ($urandom_range(0, 3) == 0);
      end
      stopout_v[d] = so;
      pushin_v[d]  = 1'($urandom_range(0, 1));
      firstin_v[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_issue = !so && iss < 25;
      exp_push  = (j >= l) ? hist[j-l] : 1'b0;
      exp_first = exp_push && hl[j-l] == 0;
      check_output("ul_phase",  32'(phase_o[d]),  3);
      check_output("ul_stopin", 32'(stopin_o[d]), 1);
      check_output("ul_rsel",   32'(rsel_o[d]),   n % 2);
      check_output("ul_rnd",    32'(rnd_o[d]),    0);
      check_output("ul_wr",     32'(wr_o[d]),     0);
      check_output("ul_err",    32'(err_o[d]),    0);
      if (exp_issue) begin
        check_output("ul_rax", 32'(rax_o[d]), iss % 5);
        check_output("ul_ray", 32'(ray_o[d]), iss / 5);
      end
      check_output("ul_pushout",  32'(pushout_o[d]),  32'(exp_push));
      check_output("ul_firstout", 32'(firstout_o[d]), 32'(exp_first));
      hist.push_back(exp_issue);
      hl.push_back(iss);
      if (exp_issue) iss++;
      if (exp_push) pout++;
      j++;
    end
    check_output("ul_done_in_budget", 32'(pout), 25);
    @(posedge clk); #1;
    stopout_v[d] = 1'b0;
    pushin_v[d]  = 1'b0;
    firstin_v[d] = 1'b0;
    @(negedge clk);
    check_output("end_phase",   32'(phase_o[d]),   0);
    check_output("end_stopin",  32'(stopin_o[d]),  0);
    check_output("end_pushout", 32'(pushout_o[d]), 0);
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pushin_v[d]  = 1'b1;
      firstin_v[d] = 1'b1;
      stopout_v[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_zero(0);
    check_zero(1);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      pushin_v[d]  = 1'b0;
      firstin_v[d] = 1'b0;
    end

    $display("[TB] stray word in IDLE");
    @(posedge clk); #1;
    pushin_v[0] = 1'b1;
    @(negedge clk);
    check_output("idle_stray_wr",  32'(wr_o[0]),    0);
    check_output("idle_stray_err", 32'(err_o[0]),   0);
    @(posedge clk); #1;
    pushin_v[0] = 1'b0;
    @(negedge clk);
    check_output("idle_err_pulse", 32'(err_o[0]),   1);
    check_output("idle_phase",     32'(phase_o[0]), 0);
    check_output("idle_no_wr",     32'(wr_o[0]),    0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("idle_err_clear", 32'(err_o[0]),   0);

    $display("[TB] block with resync at lane 7 and UNLOAD stall");
    load_block(0, 7, 1'b1);
    run_rounds(0, -1);
    run_unload(0, 1'b1);

    $display("[TB] NROUNDS=3 LAT=2 block");
    load_block(1, -1, 1'b1);
    run_rounds(1, -1);
    run_unload(1, 1'b0);

    $display("[TB] reset during round 5, then a fresh block");
    load_block(0, -1, 1'b0);
    run_rounds(0, 5);
    load_block(0, -1, 1'b1);
    run_rounds(0, -1);
    run_unload(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
